// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundles the execute-side handshake, the data-memory response and the
// register-file write port of the writeback stage.
//   master : drives ex_* and mem_* and observes ex_ready and the write/status outputs
//   slave  : the writeback stage itself
interface writeback_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_wen;
    logic        ex_is_load;
    logic [4:0]  ex_dst;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_reg;
    logic [4:0]  dstreg_addr;
    logic [31:0] dstreg_data;
    logic        load_fault;
    logic        load_timeout;

    modport master (
        output ex_valid, ex_wen, ex_is_load, ex_dst, ex_funct3, ex_addr_lo, ex_result,
        output mem_rvalid, mem_rdata,
        input  ex_ready, write_reg, dstreg_addr, dstreg_data, load_fault, load_timeout
    );

    modport slave (
        input  ex_valid, ex_wen, ex_is_load, ex_dst, ex_funct3, ex_addr_lo, ex_result,
        input  mem_rvalid, mem_rdata,
        output ex_ready, write_reg, dstreg_addr, dstreg_data, load_fault, load_timeout
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: drives the register-file write port. ALU results are written one cycle after
// acceptance; loads wait (up to MAX_WAIT cycles) for the memory response, then the selected
// byte/half/word is extracted, extended and written. Misaligned/unsupported loads and response
// timeouts are reported as single-cycle pulses.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : writeback_stage_if.slave (ex_* handshake in, mem_* response in, write port out)
module writeback_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       dst_q, dst_d;
    logic             wen_q, wen_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lo_q, lo_d;
    logic             write_reg_q, write_reg_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             fault_q, fault_d;
    logic             timeout_q, timeout_d;

    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = lo[0];
            3'b010:         load_bad = (lo != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'b0, b};
            3'b101:  extract = {16'b0, h};
            default: extract = rdata;
        endcase
    endfunction

    assign bus.ex_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        wen_d       = wen_q;
        funct3_d    = funct3_q;
        lo_d        = lo_q;
        write_reg_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        fault_d     = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ex_valid) begin
                    if (!bus.ex_is_load) begin
                        write_reg_d = bus.ex_wen & (bus.ex_dst != 5'd0);
                        addr_d      = bus.ex_dst;
                        data_d      = bus.ex_result;
                    end else if (load_bad(bus.ex_funct3, bus.ex_addr_lo)) begin
                        fault_d = 1'b1;
                    end else begin
                        dst_d    = bus.ex_dst;
                        wen_d    = bus.ex_wen;
                        funct3_d = bus.ex_funct3;
                        lo_d     = bus.ex_addr_lo;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end
                end
            end
            default: begin
                // A response in the final wait cycle takes priority over the timeout.
                if (bus.mem_rvalid) begin
                    write_reg_d = wen_q & (dst_q != 5'd0);
                    addr_d      = dst_q;
                    data_d      = extract(funct3_q, lo_q, bus.mem_rdata);
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dst_q       <= '0;
            wen_q       <= 1'b0;
            funct3_q    <= '0;
            lo_q        <= '0;
            write_reg_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            fault_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            wen_q       <= wen_d;
            funct3_q    <= funct3_d;
            lo_q        <= lo_d;
            write_reg_q <= write_reg_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            fault_q     <= fault_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.write_reg    = write_reg_q;
    assign bus.dstreg_addr  = addr_q;
    assign bus.dstreg_data  = data_q;
    assign bus.load_fault   = fault_q;
    assign bus.load_timeout = timeout_q;
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    localparam int unsigned MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if bus();

    writeback_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0 = register write, 1 = load_fault, 2 = load_timeout
    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rdata);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = rdata >> (8 * lo);
        sh_w = rdata >> (lo[1] ? 16 : 0);
        case (f3)
            3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
            3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
            3'b100:  return {24'h0, sb_w[7:0]};
            3'b101:  return {16'h0, sh_w[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if ((f3 == 3'b001 || f3 == 3'b101) && lo[0]) return 1'b1;
        if (f3 == 3'b010 && lo != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Scoreboard: every pulse on the write/status outputs must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.write_reg || bus.load_fault || bus.load_timeout)) begin : mon
            int   k;
            exp_t e;
            k = bus.write_reg ? 0 : (bus.load_fault ? 1 : 2);
            check_eq("single_pulse", $countones({bus.write_reg, bus.load_fault, bus.load_timeout}),
                     32'd1);
            if (sb.size() == 0) begin
                check_eq("spurious_pulse", {29'b0, bus.write_reg, bus.load_fault,
                                            bus.load_timeout}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("event_kind", k, e.kind);
                if (e.kind == 0) begin
                    check_eq("wb_addr", {27'b0, bus.dstreg_addr}, {27'b0, e.addr});
                    check_eq("wb_data", bus.dstreg_data, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic wen, input logic [4:0] dst, input logic [31:0] res);
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b0;
        bus.ex_wen     = wen;
        bus.ex_dst     = dst;
        bus.ex_result  = res;
        if (wen && dst != 5'd0) sb.push_back('{kind: 0, addr: dst, data: res});
        step();
        bus.ex_valid = 1'b0;
        check_eq("alu_write_reg", {31'b0, bus.write_reg}, {31'b0, (wen && dst != 5'd0)});
    endtask

    // delay = WAIT cycle (1..MAX_WAIT) in which mem_rvalid is pulsed; 0 = never respond.
    task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] dst,
                           input logic [31:0] rdata, input int delay);
        logic bad;
        bad            = ref_bad(f3, lo);
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_wen     = 1'b1;
        bus.ex_dst     = dst;
        bus.ex_funct3  = f3;
        bus.ex_addr_lo = lo;
        bus.ex_result  = 32'hA5A5_A5A5;
        if (bad) sb.push_back('{kind: 1, addr: 5'd0, data: 32'd0});
        step();
        bus.ex_valid = 1'b0;
        if (bad) begin
            check_eq("fault_pulse", {31'b0, bus.load_fault}, 32'd1);
            check_eq("fault_ready", {31'b0, bus.ex_ready}, 32'd1);
            check_eq("fault_no_write", {31'b0, bus.write_reg}, 32'd0);
            return;
        end
        check_eq("wait_ready", {31'b0, bus.ex_ready}, 32'd0);
        if (delay == 0) begin
            sb.push_back('{kind: 2, addr: 5'd0, data: 32'd0});
            repeat (MAX_WAIT - 1) step();
            check_eq("timeout_early", {31'b0, bus.load_timeout}, 32'd0);
            check_eq("wait_ready_last", {31'b0, bus.ex_ready}, 32'd0);
            step();
            check_eq("timeout_pulse", {31'b0, bus.load_timeout}, 32'd1);
            check_eq("timeout_ready", {31'b0, bus.ex_ready}, 32'd1);
        end else begin
            repeat (delay - 1) step();
            check_eq("wait_ready_resp", {31'b0, bus.ex_ready}, 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            if (dst != 5'd0) sb.push_back('{kind: 0, addr: dst, data: ref_extract(f3, lo, rdata)});
            step();
            bus.mem_rvalid = 1'b0;
            check_eq("load_write_reg", {31'b0, bus.write_reg}, {31'b0, (dst != 5'd0)});
            check_eq("load_no_timeout", {31'b0, bus.load_timeout}, 32'd0);
            check_eq("load_ready", {31'b0, bus.ex_ready}, 32'd1);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.ex_wen     = 1'b0;
        bus.ex_is_load = 1'b0;
        bus.ex_dst     = '0;
        bus.ex_funct3  = '0;
        bus.ex_addr_lo = '0;
        bus.ex_result  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();
        check_eq("rst_write_reg", {31'b0, bus.write_reg}, 32'd0);
        check_eq("rst_addr", {27'b0, bus.dstreg_addr}, 32'd0);
        check_eq("rst_data", bus.dstreg_data, 32'd0);
        check_eq("rst_ready", {31'b0, bus.ex_ready}, 32'd1);
        rst = 1'b0;
        step();

        // ALU write, then the pulse must drop
        alu_op(1'b1, 5'd5, 32'hDEADBEEF);
        check_eq("alu_data", bus.dstreg_data, 32'hDEADBEEF);
        step();
        check_eq("alu_pulse_drop", {31'b0, bus.write_reg}, 32'd0);

        // Back-to-back ALU accepts
        for (int i = 0; i < 4; i++) begin
            bus.ex_valid   = 1'b1;
            bus.ex_is_load = 1'b0;
            bus.ex_wen     = 1'b1;
            bus.ex_dst     = 5'(i + 10);
            bus.ex_result  = 32'h1000_0000 + 32'(i);
            sb.push_back('{kind: 0, addr: 5'(i + 10), data: 32'h1000_0000 + 32'(i)});
            step();
        end
        bus.ex_valid = 1'b0;
        alu_op(1'b1, 5'd0, 32'h1234_5678);   // x0: no write
        alu_op(1'b0, 5'd9, 32'h1234_5678);   // wen=0: no write

        // Loads with sign/zero extension
        load_op(3'b000, 2'd3, 5'd6, 32'h80FF1234, 2);
        check_eq("lb_data", bus.dstreg_data, 32'hFFFFFF80);
        load_op(3'b100, 2'd3, 5'd6, 32'h80FF1234, 2);
        check_eq("lbu_data", bus.dstreg_data, 32'h00000080);
        load_op(3'b001, 2'd2, 5'd7, 32'h80010000, 1);
        check_eq("lh_data", bus.dstreg_data, 32'hFFFF8001);
        load_op(3'b101, 2'd2, 5'd7, 32'h80010000, 3);
        check_eq("lhu_data", bus.dstreg_data, 32'h00008001);
        load_op(3'b010, 2'd0, 5'd8, 32'hCAFEF00D, 1);
        check_eq("lw_data", bus.dstreg_data, 32'hCAFEF00D);

        // Faults
        load_op(3'b001, 2'd1, 5'd7, 32'h0, 1);
        load_op(3'b010, 2'd2, 5'd7, 32'h0, 1);
        load_op(3'b011, 2'd0, 5'd7, 32'h0, 1);
        load_op(3'b110, 2'd0, 5'd7, 32'h0, 1);

        // Timeout, then response in the last WAIT cycle
        load_op(3'b010, 2'd0, 5'd3, 32'h0, 0);
        load_op(3'b010, 2'd0, 5'd3, 32'h0BAD_F00D, MAX_WAIT);
        check_eq("last_cycle_data", bus.dstreg_data, 32'h0BAD_F00D);

        // Load to x0 consumes the response without writing
        load_op(3'b000, 2'd1, 5'd0, 32'h0000_7F00, 2);

        // A few randomised legal loads
        for (int i = 0; i < 6; i++) begin
            logic [2:0] f3;
            logic [1:0] lo;
            case ($urandom_range(0, 4))
                0: begin f3 = 3'b000; lo = 2'($urandom_range(0, 3)); end
                1: begin f3 = 3'b100; lo = 2'($urandom_range(0, 3)); end
                2: begin f3 = 3'b001; lo = {1'($urandom_range(0, 1)), 1'b0}; end
                3: begin f3 = 3'b101; lo = {1'($urandom_range(0, 1)), 1'b0}; end
                default: begin f3 = 3'b010; lo = 2'd0; end
            endcase
            load_op(f3, lo, 5'($urandom_range(1, 31)), $urandom, int'($urandom_range(1, 5)));
        end

        // Stray response in IDLE
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        step();
        bus.mem_rvalid = 1'b0;
        check_eq("stray_no_write", {31'b0, bus.write_reg}, 32'd0);

        // Reset in the middle of WAIT aborts the load
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_wen     = 1'b1;
        bus.ex_dst     = 5'd12;
        bus.ex_funct3  = 3'b010;
        bus.ex_addr_lo = 2'd0;
        step();
        bus.ex_valid = 1'b0;
        step();
        rst = 1'b1;
        #2;
        check_eq("midrst_write_reg", {31'b0, bus.write_reg}, 32'd0);
        check_eq("midrst_addr", {27'b0, bus.dstreg_addr}, 32'd0);
        check_eq("midrst_data", bus.dstreg_data, 32'd0);
        check_eq("midrst_ready", {31'b0, bus.ex_ready}, 32'd1);
        step();
        rst = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
        step();
        bus.mem_rvalid = 1'b0;
        check_eq("postrst_no_write", {31'b0, bus.write_reg}, 32'd0);
        check_eq("postrst_data", bus.dstreg_data, 32'd0);
        check_eq("postrst_ready", {31'b0, bus.ex_ready}, 32'd1);

        repeat (3) step();
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
